// File: rtl/alu_step_sequencer_if.sv
// Button-side request lines and datapath strobe bundle for the ALU step sequencer.
// master: whoever drives step/abort (board button logic); slave: the sequencer.
// Pure wiring, no storage.
interface alu_step_sequencer_if;
  logic       step;
  logic       abort;
  logic       reg_clr;
  logic       ld_a;
  logic       ld_b;
  logic       ld_op;
  logic       ld_res;
  logic       done;
  logic       busy;
  logic [2:0] stage;

  modport master (
    output step, abort,
    input  reg_clr, ld_a, ld_b, ld_op, ld_res, done, busy, stage
  );

  modport slave (
    input  step, abort,
    output reg_clr, ld_a, ld_b, ld_op, ld_res, done, busy, stage
  );
endinterface

// File: rtl/alu_step_sequencer.sv
// Step-button FSM sequencing clear / load A / load B / load op / exec wait / result capture.
// Latency: strobe 1 cycle after qualified step (+2 with ALU_SEQ_BTN_SYNC_EN defined); EXEC lasts EXEC_CYCLES.
// No backpressure: step is ignored while in EXEC and never queued; abort always wins over step.
module alu_step_sequencer #(
  parameter int EXEC_CYCLES = 2  // legal 1..15, counter is 4 bits
) (
  input  logic                 clk,
  input  logic                 clr_n,
  alu_step_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ENTER_A  = 3'd1,
    ENTER_B  = 3'd2,
    ENTER_OP = 3'd3,
    EXEC     = 3'd4,
    SHOW     = 3'd5
  } state_t;

  localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       reg_clr_q;
  logic       ld_a_q;
  logic       ld_b_q;
  logic       ld_op_q;
  logic       ld_res_q;
  logic       stp;
  logic       abt;

`ifdef ALU_SEQ_BTN_SYNC_EN
  logic step_s1;
  logic step_s2;
  logic step_s3;
  logic abort_s1;
  logic abort_s2;

  // Two-flop synchronizers for both buttons plus a delay flop for step edge detect
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      step_s1  <= 1'b0;
      step_s2  <= 1'b0;
      step_s3  <= 1'b0;
      abort_s1 <= 1'b0;
      abort_s2 <= 1'b0;
    end else begin
      step_s1  <= bus.step;
      step_s2  <= step_s1;
      step_s3  <= step_s2;
      abort_s1 <= bus.abort;
      abort_s2 <= abort_s1;
    end
  end

  // A held button yields one event; abort stays a level
  assign stp = step_s2 & ~step_s3;
  assign abt = abort_s2;
`else
  // Inputs already synchronous; step is a single-cycle pulse from the caller
  assign stp = bus.step;
  assign abt = bus.abort;
`endif

  // Sequencer state, exec counter and one-cycle registered strobes
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      reg_clr_q <= 1'b0;
      ld_a_q    <= 1'b0;
      ld_b_q    <= 1'b0;
      ld_op_q   <= 1'b0;
      ld_res_q  <= 1'b0;
    end else begin
      reg_clr_q <= 1'b0;
      ld_a_q    <= 1'b0;
      ld_b_q    <= 1'b0;
      ld_op_q   <= 1'b0;
      ld_res_q  <= 1'b0;
      if (abt) begin
        // Abort clears the datapath even when already idle
        state     <= IDLE;
        cnt       <= 4'd0;
        reg_clr_q <= 1'b1;
      end else begin
        case (state)
          IDLE: if (stp) begin
            state     <= ENTER_A;
            reg_clr_q <= 1'b1;
          end
          ENTER_A: if (stp) begin
            state  <= ENTER_B;
            ld_a_q <= 1'b1;
          end
          ENTER_B: if (stp) begin
            state  <= ENTER_OP;
            ld_b_q <= 1'b1;
          end
          ENTER_OP: if (stp) begin
            state   <= EXEC;
            ld_op_q <= 1'b1;
            cnt     <= EXEC_LOAD;
          end
          EXEC: begin
            // Fixed ALU settle time; step presses here are dropped
            if (cnt != 4'd0) begin
              cnt <= cnt - 4'd1;
            end else begin
              state    <= SHOW;
              ld_res_q <= 1'b1;
            end
          end
          SHOW: if (stp) begin
            state     <= ENTER_A;
            reg_clr_q <= 1'b1;
          end
          default: begin
            // Unreachable codes recover to IDLE with a clean datapath
            state     <= IDLE;
            cnt       <= 4'd0;
            reg_clr_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.reg_clr = reg_clr_q;
  assign bus.ld_a    = ld_a_q;
  assign bus.ld_b    = ld_b_q;
  assign bus.ld_op   = ld_op_q;
  assign bus.ld_res  = ld_res_q;
  assign bus.done    = ld_res_q;
  assign bus.busy    = (state == EXEC);
  assign bus.stage   = state;

endmodule

// File: tb/tb_alu_step_sequencer.sv
// Scoreboard bench for alu_step_sequencer: three instances with EXEC_CYCLES 1, 2 and 15.
// Stimulus pushes expected strobe events; a negedge monitor pops and compares them.
// Also runs a held-step test when ALU_SEQ_BTN_SYNC_EN is defined.
module tb_alu_step_sequencer;

`ifdef ALU_SEQ_BTN_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    int         cyc;
    logic [4:0] strb;   // {ld_res, ld_op, ld_b, ld_a, reg_clr}
    logic [2:0] stage;
  } exp_t;

  logic       clk;
  logic       clr_n;
  logic [2:0] step_v;
  logic [2:0] abort_v;
  int         cyc;
  int         checks;
  int         errors;
  int         brun [3];
  int         ecyc [3];
  exp_t       expq [3][$];

  logic [4:0] strb_v  [3];
  logic       done_v  [3];
  logic       busy_v  [3];
  logic [2:0] stage_v [3];

  alu_step_sequencer_if if0 ();
  alu_step_sequencer_if if1 ();
  alu_step_sequencer_if if2 ();

  alu_step_sequencer #(.EXEC_CYCLES(1))  u_dut0 (.clk(clk), .clr_n(clr_n), .bus(if0));
  alu_step_sequencer #(.EXEC_CYCLES(2))  u_dut1 (.clk(clk), .clr_n(clr_n), .bus(if1));
  alu_step_sequencer #(.EXEC_CYCLES(15)) u_dut2 (.clk(clk), .clr_n(clr_n), .bus(if2));

  assign if0.step = step_v[0];  assign if0.abort = abort_v[0];
  assign if1.step = step_v[1];  assign if1.abort = abort_v[1];
  assign if2.step = step_v[2];  assign if2.abort = abort_v[2];

  assign strb_v[0] = {if0.ld_res, if0.ld_op, if0.ld_b, if0.ld_a, if0.reg_clr};
  assign strb_v[1] = {if1.ld_res, if1.ld_op, if1.ld_b, if1.ld_a, if1.reg_clr};
  assign strb_v[2] = {if2.ld_res, if2.ld_op, if2.ld_b, if2.ld_a, if2.reg_clr};
  assign done_v[0] = if0.done;  assign busy_v[0] = if0.busy;  assign stage_v[0] = if0.stage;
  assign done_v[1] = if1.done;  assign busy_v[1] = if1.busy;  assign stage_v[1] = if1.stage;
  assign done_v[2] = if2.done;  assign busy_v[2] = if2.busy;  assign stage_v[2] = if2.stage;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int d, input int c, input logic [4:0] s, input logic [2:0] st);
    exp_t e;
    e.cyc   = c;
    e.strb  = s;
    e.stage = st;
    expq[d].push_back(e);
  endtask

  // Issue one step pulse to every instance and expect the given strobe/stage
  task automatic step_all(input logic [4:0] s, input logic [2:0] st);
    for (int d = 0; d < 3; d++) push(d, cyc + LAT, s, st);
    step_v = 3'b111;
    tick(1);
    step_v = 3'b000;
    tick(3);
  endtask

  task automatic check_quiet(input string name);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (strb_v[d] !== 5'd0 || done_v[d] !== 1'b0 || busy_v[d] !== 1'b0 || stage_v[d] !== 3'd0) begin
        errors++;
        $display("FAIL %s dut%0d got strb=%b done=%b busy=%b stage=%0d, want all zero",
                 name, d, strb_v[d], done_v[d], busy_v[d], stage_v[d]);
      end
    end
  endtask

  // Per-instance monitor: any strobe or done must match the head of the queue
  task automatic mon(input int d);
    exp_t e;
    if (!clr_n) begin
      brun[d] = 0;
      return;
    end
    if (busy_v[d]) brun[d]++;
    if (strb_v[d] != 5'd0 || done_v[d]) begin
      checks++;
      if (expq[d].size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe dut%0d cyc %0d got strb=%b done=%b stage=%0d, none expected",
                 d, cyc, strb_v[d], done_v[d], stage_v[d]);
      end else begin
        e = expq[d].pop_front();
        if (e.cyc != cyc || e.strb != strb_v[d] || e.stage != stage_v[d] || done_v[d] != e.strb[4]) begin
          errors++;
          $display("FAIL strobe dut%0d got cyc=%0d strb=%b done=%b stage=%0d, want cyc=%0d strb=%b done=%b stage=%0d",
                   d, cyc, strb_v[d], done_v[d], stage_v[d], e.cyc, e.strb, e.strb[4], e.stage);
        end
      end
      if (strb_v[d][4]) begin
        checks++;
        if (brun[d] != ecyc[d]) begin
          errors++;
          $display("FAIL busy_width dut%0d got %0d cycles, want %0d", d, brun[d], ecyc[d]);
        end
        brun[d] = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) mon(d);
  end

  initial begin
    int c_op;
    int x0;
    ecyc    = '{1, 2, 15};
    brun    = '{0, 0, 0};
    cyc     = 0;
    checks  = 0;
    errors  = 0;
    clr_n   = 1'b0;
    step_v  = 3'b111;
    abort_v = 3'b000;

    // Reset held with step high: everything stays zero
    tick(3);
    check_quiet("reset_state");
    step_v = 3'b000;
    tick(1);
    clr_n = 1'b1;
    tick(5);
    check_quiet("idle_after_release");

    // Full sequence on all instances
    step_all(5'b00001, 3'd1);
    step_all(5'b00010, 3'd2);
    step_all(5'b00100, 3'd3);
    c_op = cyc;
    for (int d = 0; d < 3; d++) push(d, c_op + LAT, 5'b01000, 3'd4);
    x0 = c_op + LAT;
    for (int d = 0; d < 3; d++) push(d, x0 + ecyc[d], 5'b10000, 3'd5);
    step_v = 3'b111;
    tick(1);
    step_v = 3'b000;
    // Step during the long EXEC of the 15-cycle instance is dropped
    while (cyc < x0 + 3) tick(1);
    step_v = 3'b100;
    tick(1);
    step_v = 3'b000;
    while (cyc < x0 + 15 + LAT + 2) tick(1);

    // New calculation from SHOW, then abort+step together in ENTER_B
    step_all(5'b00001, 3'd1);
    step_all(5'b00010, 3'd2);
    for (int d = 0; d < 3; d++) push(d, cyc + LAT, 5'b00001, 3'd0);
    step_v  = 3'b111;
    abort_v = 3'b111;
    tick(1);
    step_v  = 3'b000;
    abort_v = 3'b000;
    tick(3);
    // Abort while already idle still clears
    for (int d = 0; d < 3; d++) push(d, cyc + LAT, 5'b00001, 3'd0);
    abort_v = 3'b111;
    tick(1);
    abort_v = 3'b000;
    tick(4);

    // Reset one cycle into EXEC: no result capture afterwards
    step_all(5'b00001, 3'd1);
    step_all(5'b00010, 3'd2);
    step_all(5'b00100, 3'd3);
    c_op = cyc;
    for (int d = 0; d < 3; d++) push(d, c_op + LAT, 5'b01000, 3'd4);
    x0 = c_op + LAT;
    step_v = 3'b111;
    tick(1);
    step_v = 3'b000;
    while (cyc < x0) tick(1);
    @(negedge clk);
    #2;
    clr_n = 1'b0;
    #1;
    check_quiet("async_reset_mid_exec");
    tick(2);
    clr_n = 1'b1;
    tick(25);
    check_quiet("after_mid_exec_reset");

`ifdef ALU_SEQ_BTN_SYNC_EN
    // Held step: one event only, stage parks at ENTER_A
    x0 = cyc;
    for (int d = 0; d < 3; d++) push(d, x0 + 3, 5'b00001, 3'd1);
    step_v = 3'b111;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (cyc >= x0 + 3) begin
        for (int d = 0; d < 3; d++) begin
          checks++;
          if (stage_v[d] !== 3'd1) begin
            errors++;
            $display("FAIL held_step_stage dut%0d cyc %0d got %0d, want 1", d, cyc, stage_v[d]);
          end
        end
      end
    end
    step_v = 3'b000;
    tick(4);
`endif

    // Every expected event must have been seen
    tick(3);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (expq[d].size() != 0) begin
        errors++;
        $display("FAIL missing_strobe dut%0d got %0d unmatched expected events, want 0", d, expq[d].size());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
